tm1638_frame_sequencer: RTL and testbench
=========================================

Name: tm1638_frame_sequencer

Overview:
Frame-level controller for the TM1638 display path. It arbitrates between a display-data update requester, a brightness requester and an internal periodic refresh timer. It builds the TM1638 command/data byte sequence and feeds it to the downstream byte-serial engine over a valid/ready byte handshake. The byte engine owns the STB/CLK/DIO pins; this block owns ordering, framing and buffering.

Parameters:
REFRESH_CYCLES, 1_000_000, clk cycles between automatic full-frame refreshes (>= 64)
DEF_BRIGHT, 3'd7, brightness loaded at reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
upd_req  in  1  display update request; held high until upd_ack
data_in  in  128  display image; [127:120] = address 0x00, [7:0] = address 0x0F
upd_ack  out  1  one-cycle pulse: data_in captured
bright_req  in  1  brightness/on-off change request; held high until bright_ack
bright_in  in  3  new brightness level
disp_on_in  in  1  new display-on flag
bright_ack  out  1  one-cycle pulse: bright_in/disp_on_in captured
tx_byte  out  8  byte to engine
tx_last  out  1  engine releases STB after this byte
tx_valid  out  1  tx_byte/tx_last valid
tx_ready  in  1  engine accepts byte when tx_valid && tx_ready
tx_idle  in  1  engine has shifted all accepted bytes and STB is high
busy  out  1  high from frame start through final tx_idle
frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset values: tx_valid=0, tx_byte=0, tx_last=0, upd_ack=0, bright_ack=0, busy=0, frame_done=0. The image buffer is cleared to 0, bright=DEF_BRIGHT, disp_on=1, refresh counter=0, and refresh_pend=1 so that the first frame after reset reinitialises the display.
- Constants: MODE=8'h40 (write, auto-increment), ADDR=8'hC0, CTRL={4'b1000, disp_on, bright}.
- States: IDLE, MODE, WAIT_MODE, ADDR, DATA, WAIT_DATA, CTRL, WAIT_CTRL, DONE.
- Arbitration happens in IDLE only. Priority: upd_req, then bright_req, then refresh_pend.
  - upd_req (with or without bright_req): full frame. If bright_req is also high, both are captured and both acks pulse in the same cycle.
  - bright_req alone: CTRL-only frame.
  - refresh_pend alone: full frame using the current buffer.
- Latency: a request sampled high in IDLE at edge N gives ack high in cycle N+1, busy=1, and tx_valid=1 with the first byte in cycle N+1.
- Full frame:
  - MODE with tx_last=1; wait tx_idle.
  - ADDR with tx_last=0, then 16 data bytes in address order, tx_last=1 on the 16th; wait tx_idle.
  - CTRL with tx_last=1; wait tx_idle.
  - DONE: frame_done pulses, busy drops, return to IDLE.
- CTRL-only frame: CTRL with tx_last=1; wait tx_idle; DONE.
- Handshake rules:
  - tx_byte and tx_last hold stable while tx_valid && !tx_ready.
  - Inside the ADDR+data burst, tx_valid may stay high across consecutive transfers (one byte per cycle at full throughput).
  - After any tx_last byte is accepted, tx_valid=0 until tx_idle is seen high. This guarantees the STB gap.
- The data byte index is 4 bits, counts 0..15 and is cleared at frame start.
- Input decoupling: data_in, bright_in and disp_on_in are used only at capture. Changes during a frame do not affect that frame.
- Refresh timer:
  - Counts every cycle and wraps at REFRESH_CYCLES-1, setting refresh_pend.
  - Starting a full frame clears refresh_pend and restarts the counter.
  - A wrap during a frame leaves refresh_pend set, so the next refresh is served after that frame.
- Requests arriving while busy wait. The acks are never asserted outside the cycle after IDLE.
- tx_ready high while tx_valid=0 is ignored. A tx_idle pulse outside the WAIT_* states is ignored.
- rst mid-frame: all outputs take reset values on the next cycle, tx_valid drops immediately, and the partial frame is abandoned. refresh_pend=1 forces a full re-init frame.

Test Plan:
- Reset, tx_ready=1, tx_idle returns 4 cycles after each tx_last -> full frame: 40, C0, 16x 00, 8F; the three tx_last bytes are 40, 16th data, 8F; one frame_done.
- upd_req with data_in=128'h9C00_76FF_6E00_EFFF_9C00_76FF_6E00_EFFF -> upd_ack 1 cycle later; data bytes 9C,00,76,FF,... in order; data_in changed after ack does not alter the frame.
- bright_req alone, bright_in=3, disp_on_in=1 -> bright_ack; single byte 8B with tx_last=1; busy spans until tx_idle.
- upd_req and bright_req together (bright_in=0, disp_on_in=0) -> both acks in the same cycle; one full frame ending with CTRL=80.
- tx_ready toggled randomly during the data burst -> tx_byte stable while stalled; exactly 16 data bytes, no skip or duplicate.
- REFRESH_CYCLES=64 with no requests -> a full frame roughly every 64 cycles after the previous frame starts. Asserting rst in the middle of a data burst drops tx_valid next cycle, then a fresh full frame starting with 40 follows.

Source files
------------

// File: rtl/tm1638_frame_sequencer.sv
// TM1638 frame sequencer: arbitrates image updates, brightness changes and periodic
// refresh, then streams the command/data bytes of one frame to the byte-serial engine.
module tm1638_frame_sequencer #(
    parameter int         REFRESH_CYCLES = 1_000_000,
    parameter logic [2:0] DEF_BRIGHT     = 3'd7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         upd_req,
    input  logic [127:0] data_in,
    output logic         upd_ack,
    input  logic         bright_req,
    input  logic [2:0]   bright_in,
    input  logic         disp_on_in,
    output logic         bright_ack,
    output logic [7:0]   tx_byte,
    output logic         tx_last,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic         tx_idle,
    output logic         busy,
    output logic         frame_done
);
    localparam int               CNT_W    = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [7:0]       CMD_MODE = 8'h40;
    localparam logic [7:0]       CMD_ADDR = 8'hC0;

    typedef enum logic [3:0] {
        S_IDLE, S_MODE, S_WAIT_MODE, S_ADDR, S_DATA,
        S_WAIT_DATA, S_CTRL, S_WAIT_CTRL, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       image [16];
    logic [2:0]       bright;
    logic             disp_on;
    logic [3:0]       idx;
    logic [CNT_W-1:0] refresh_cnt;
    logic             refresh_pend;
    logic             take_upd, take_bright, start_full;
    logic [7:0]       ctrl_byte;

    assign ctrl_byte  = {4'b1000, disp_on, bright};
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign frame_done = (state == S_DONE);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        take_upd    = 1'b0;
        take_bright = 1'b0;
        start_full  = 1'b0;
        tx_valid    = 1'b0;
        tx_byte     = 8'h00;
        tx_last     = 1'b0;
        case (state)
            S_IDLE: begin
                if (upd_req) begin
                    take_upd    = 1'b1;
                    take_bright = bright_req;
                    start_full  = 1'b1;
                    state_nxt   = S_MODE;
                end else if (bright_req) begin
                    take_bright = 1'b1;
                    state_nxt   = S_CTRL;
                end else if (refresh_pend) begin
                    start_full = 1'b1;
                    state_nxt  = S_MODE;
                end
            end
            S_MODE: begin
                tx_valid = 1'b1;
                tx_byte  = CMD_MODE;
                tx_last  = 1'b1;
                if (tx_ready) state_nxt = S_WAIT_MODE;
            end
            S_WAIT_MODE: if (tx_idle) state_nxt = S_ADDR;
            S_ADDR: begin
                tx_valid = 1'b1;
                tx_byte  = CMD_ADDR;
                if (tx_ready) state_nxt = S_DATA;
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_byte  = image[idx];
                tx_last  = (idx == 4'd15);
                if (tx_ready && idx == 4'd15) state_nxt = S_WAIT_DATA;
            end
            S_WAIT_DATA: if (tx_idle) state_nxt = S_CTRL;
            S_CTRL: begin
                tx_valid = 1'b1;
                tx_byte  = ctrl_byte;
                tx_last  = 1'b1;
                if (tx_ready) state_nxt = S_WAIT_CTRL;
            end
            S_WAIT_CTRL: if (tx_idle) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            upd_ack      <= 1'b0;
            bright_ack   <= 1'b0;
            bright       <= DEF_BRIGHT;
            disp_on      <= 1'b1;
            idx          <= 4'd0;
            refresh_cnt  <= '0;
            refresh_pend <= 1'b1;
            // NOTE: the image is a 16-byte flop array, not a RAM, so it can be cleared on reset.
            for (int i = 0; i < 16; i++) image[i] <= 8'h00;
        end else begin
            state      <= state_nxt;
            upd_ack    <= take_upd;
            bright_ack <= take_bright;
            if (take_upd) begin
                for (int i = 0; i < 16; i++) image[i] <= data_in[127-8*i -: 8];
            end
            if (take_bright) begin
                bright  <= bright_in;
                disp_on <= disp_on_in;
            end
            if (start_full) idx <= 4'd0;
            else if (state == S_DATA && tx_ready) idx <= idx + 4'd1;
            // A frame start wins over a coincident wrap; a wrap mid-frame stays pending.
            if (start_full) begin
                refresh_cnt  <= '0;
                refresh_pend <= 1'b0;
            end else if (refresh_cnt == CNT_MAX) begin
                refresh_cnt  <= '0;
                refresh_pend <= 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
// Bench for tm1638_frame_sequencer: an engine model answers the byte stream, and a
// frame-level model predicts every accepted byte, checked on each clock.
module tb_tm1638_frame_sequencer;
    localparam int REFRESH = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         upd_req, bright_req, disp_on_in;
    logic [127:0] data_in;
    logic [2:0]   bright_in;
    logic         upd_ack, bright_ack, tx_last, tx_valid, busy, frame_done;
    logic [7:0]   tx_byte;
    logic         tx_ready = 1'b1;
    logic         tx_idle  = 1'b1;

    always #5 clk = ~clk;

    tm1638_frame_sequencer #(.REFRESH_CYCLES(REFRESH), .DEF_BRIGHT(3'd7)) dut (
        .clk(clk), .rst(rst),
        .upd_req(upd_req), .data_in(data_in), .upd_ack(upd_ack),
        .bright_req(bright_req), .bright_in(bright_in), .disp_on_in(disp_on_in),
        .bright_ack(bright_ack),
        .tx_byte(tx_byte), .tx_last(tx_last), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_idle(tx_idle),
        .busy(busy), .frame_done(frame_done)
    );

    // Frame-level model: display state plus the queue of bytes the next frames must carry.
    logic [7:0] m_img [16];
    logic [2:0] m_bright;
    logic       m_on;
    logic [8:0] exp_q [$];
    logic [7:0] frame_bytes [$];
    int         starts [$];
    int         tests = 0, fails = 0, cyc = 0;
    logic       acc = 1'b0, acc_last = 1'b0, gap = 1'b0, stalled = 1'b0, prev_busy = 1'b0;
    logic [8:0] held = '0;
    int         idle_cnt = 0;
    logic       stall_mode = 1'b0;

    function automatic logic [7:0] ctrl_of();
        return {4'b1000, m_on, m_bright};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_full();
        exp_q.push_back({1'b1, 8'h40});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), m_img[i]});
        exp_q.push_back({1'b1, ctrl_of()});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_img[i] = 8'h00;
        m_bright = 3'd7;
        m_on     = 1'b1;
    endtask

    // Compare process: byte order, stall stability and the STB gap after every tx_last.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            gap = 1'b0; stalled = 1'b0; acc = 1'b0; acc_last = 1'b0; prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) starts.push_back(cyc);
            prev_busy = busy;
            if (gap) begin
                check("stb_gap_valid_low", tx_valid, 0);
                if (tx_idle) gap = 1'b0;
            end
            if (stalled && tx_valid) check("stall_hold", {tx_last, tx_byte}, held);
            acc      = tx_valid && tx_ready;
            acc_last = acc && tx_last;
            if (acc) begin
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("tx_byte_last", {tx_last, tx_byte}, exp_q.pop_front());
                frame_bytes.push_back(tx_byte);
                if (tx_last) gap = 1'b1;
            end
            stalled = tx_valid && !tx_ready;
            held    = {tx_last, tx_byte};
        end
    end

    // Engine model: drops tx_idle on each accepted byte and raises it 4 cycles after a tx_last.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            tx_idle  = 1'b1;
            idle_cnt = 0;
        end else if (acc_last) begin
            tx_idle  = 1'b0;
            idle_cnt = 4;
        end else if (acc) begin
            tx_idle = 1'b0;
        end else if (idle_cnt > 0) begin
            idle_cnt--;
            if (idle_cnt == 0) tx_idle = 1'b1;
        end
        tx_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic wait_frame(input string name);
        int   n  = 0;
        logic pb = 1'b0;
        while (frame_done !== 1'b1 && n < 400) begin
            pb = busy;
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, n < 400, 1);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_busy_thru_idle"}, pb, 1);
        check({name, "_busy_low_at_done"}, busy, 0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, frame_done, 0);
    endtask

    task automatic do_req(input string name, input logic upd, input logic brt,
                          input logic [127:0] img, input logic [2:0] b, input logic on);
        data_in = img; bright_in = b; disp_on_in = on;
        upd_req = upd; bright_req = brt;
        if (upd) for (int i = 0; i < 16; i++) m_img[i] = img[127-8*i -: 8];
        if (brt) begin
            m_bright = b;
            m_on     = on;
        end
        if (upd) push_full();
        else exp_q.push_back({1'b1, ctrl_of()});
        frame_bytes.delete();
        @(negedge clk);
        check({name, "_upd_ack"}, upd_ack, upd);
        check({name, "_bright_ack"}, bright_ack, brt);
        check({name, "_busy"}, busy, 1);
        check({name, "_first_valid"}, tx_valid, 1);
        check({name, "_first_byte"}, tx_byte, upd ? 8'h40 : ctrl_of());
        // Scramble the inputs right after capture; the frame must not see them.
        upd_req = 1'b0; bright_req = 1'b0;
        data_in = ~img; bright_in = ~b; disp_on_in = ~on;
        @(negedge clk);
        check({name, "_upd_ack_pulse"}, upd_ack, 0);
        check({name, "_bright_ack_pulse"}, bright_ack, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; upd_req = 1'b0; bright_req = 1'b0;
        data_in = '0; bright_in = '0; disp_on_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_upd_ack", upd_ack, 0);
        check("rst_bright_ack", bright_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);

        // Power-on re-init frame of the cleared buffer.
        push_full();
        frame_bytes.delete();
        rst = 1'b0;
        @(negedge clk);
        check("reinit_first_valid", tx_valid, 1);
        check("reinit_first_byte", tx_byte, 8'h40);
        wait_frame("reinit");
        check("reinit_len", frame_bytes.size(), 19);
        check("reinit_b1", frame_bytes[1], 8'hC0);
        check("reinit_b2", frame_bytes[2], 8'h00);
        check("reinit_ctrl", frame_bytes[18], 8'h8F);

        do_req("upd", 1'b1, 1'b0, 128'h9C00_76FF_6E00_EFFF_9C00_76FF_6E00_EFFF, 3'd0, 1'b0);
        wait_frame("upd");
        check("upd_len", frame_bytes.size(), 19);
        check("upd_d0", frame_bytes[2], 8'h9C);
        check("upd_d1", frame_bytes[3], 8'h00);
        check("upd_d2", frame_bytes[4], 8'h76);
        check("upd_d3", frame_bytes[5], 8'hFF);
        check("upd_d15", frame_bytes[17], 8'hFF);
        check("upd_ctrl", frame_bytes[18], 8'h8F);

        do_req("bright", 1'b0, 1'b1, 128'h0, 3'd3, 1'b1);
        wait_frame("bright");
        check("bright_len", frame_bytes.size(), 1);
        check("bright_ctrl", frame_bytes[0], 8'h8B);

        do_req("both", 1'b1, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3'd0, 1'b0);
        wait_frame("both");
        check("both_len", frame_bytes.size(), 19);
        check("both_d0", frame_bytes[2], 8'h01);
        check("both_d15", frame_bytes[17], 8'h10);
        check("both_ctrl", frame_bytes[18], 8'h80);

        stall_mode = 1'b1;
        do_req("stall", 1'b1, 1'b0, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 3'd0, 1'b0);
        wait_frame("stall");
        stall_mode = 1'b0;
        check("stall_len", frame_bytes.size(), 19);
        check("stall_d8", frame_bytes[10], 8'h88);
        check("stall_d15", frame_bytes[17], 8'hFF);

        // Two unrequested refresh frames of the retained image.
        push_full();
        frame_bytes.delete();
        wait_frame("refresh1");
        push_full();
        frame_bytes.delete();
        wait_frame("refresh2");
        check("refresh2_d1", frame_bytes[3], 8'h11);
        check("refresh2_ctrl", frame_bytes[18], 8'h80);
        n = starts.size();
        check("refresh_period_a", (starts[n-1] - starts[n-2]) inside {[REFRESH:REFRESH+2]}, 1);
        check("refresh_period_b", (starts[n-2] - starts[n-3]) inside {[REFRESH:REFRESH+2]}, 1);

        // Reset in the middle of the next refresh data burst.
        push_full();
        frame_bytes.delete();
        n = 0;
        while (frame_bytes.size() < 7 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("midburst_reached", n < 400, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_tx_byte", tx_byte, 0);
        check("midrst_busy", busy, 0);
        exp_q.delete();
        model_reset();
        push_full();
        frame_bytes.delete();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_first_valid", tx_valid, 1);
        check("postrst_first_byte", tx_byte, 8'h40);
        wait_frame("postrst");
        check("postrst_len", frame_bytes.size(), 19);
        check("postrst_d3", frame_bytes[5], 8'h00);
        check("postrst_ctrl", frame_bytes[18], 8'h8F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
